// File: rtl/iob_cache_back_end_axi_wbuf_if.sv
// iob_cache_back_end_axi_wbuf_if: AXI4 bus bundle between the cache back end (master) and memory (slave).
interface iob_cache_back_end_axi_wbuf_if #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int AXI_ID_W  = 1,
    parameter int AXI_LEN_W = 8
);
    logic [AXI_ID_W-1:0]  axi_awid_o, axi_arid_o;
    logic [ADDR_W-1:0]    axi_awaddr_o, axi_araddr_o;
    logic [AXI_LEN_W-1:0] axi_awlen_o, axi_arlen_o;
    logic [2:0]           axi_awsize_o, axi_arsize_o;
    logic [1:0]           axi_awburst_o, axi_arburst_o;
    logic [3:0]           axi_awcache_o, axi_arcache_o;
    logic                 axi_awvalid_o, axi_awready_i, axi_arvalid_o, axi_arready_i;
    logic [DATA_W-1:0]    axi_wdata_o;
    logic [DATA_W/8-1:0]  axi_wstrb_o;
    logic                 axi_wlast_o, axi_wvalid_o, axi_wready_i;
    logic [1:0]           axi_bresp_i;
    logic                 axi_bvalid_i, axi_bready_o;
    logic [DATA_W-1:0]    axi_rdata_i;
    logic [1:0]           axi_rresp_i;
    logic                 axi_rlast_i, axi_rvalid_i, axi_rready_o;

    modport master (
        output axi_awid_o, axi_arid_o, axi_awaddr_o, axi_araddr_o, axi_awlen_o, axi_arlen_o,
               axi_awsize_o, axi_arsize_o, axi_awburst_o, axi_arburst_o, axi_awcache_o, axi_arcache_o,
               axi_awvalid_o, axi_arvalid_o, axi_wdata_o, axi_wstrb_o, axi_wlast_o, axi_wvalid_o,
               axi_bready_o, axi_rready_o,
        input  axi_awready_i, axi_arready_i, axi_wready_i, axi_bresp_i, axi_bvalid_i,
               axi_rdata_i, axi_rresp_i, axi_rlast_i, axi_rvalid_i
    );
    modport slave (
        input  axi_awid_o, axi_arid_o, axi_awaddr_o, axi_araddr_o, axi_awlen_o, axi_arlen_o,
               axi_awsize_o, axi_arsize_o, axi_awburst_o, axi_arburst_o, axi_awcache_o, axi_arcache_o,
               axi_awvalid_o, axi_arvalid_o, axi_wdata_o, axi_wstrb_o, axi_wlast_o, axi_wvalid_o,
               axi_bready_o, axi_rready_o,
        output axi_awready_i, axi_arready_i, axi_wready_i, axi_bresp_i, axi_bvalid_i,
               axi_rdata_i, axi_rresp_i, axi_rlast_i, axi_rvalid_i
    );
endinterface

// File: rtl/iob_cache_back_end_axi_wbuf.sv
// iob_cache_back_end_axi_wbuf: cache back end with a posted-write FIFO and line refill over AXI4;
// a refill waits for older buffered writes to the same line to retire before issuing AR.
module iob_cache_back_end_axi_wbuf #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                LINE_BEATS = 4,
    parameter int                WBUF_DEPTH = 4,
    parameter int                AXI_ID_W   = 1,
    parameter logic [AXI_ID_W-1:0] AXI_ID   = '0,
    parameter int                AXI_LEN_W  = 8,
    parameter logic [3:0]        CACHE_MODE = 4'b0011,
    localparam int               NB         = $clog2(DATA_W/8),
    localparam int               LB         = $clog2(LINE_BEATS),
    localparam int               LW         = LB + NB
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   wr_valid_i,
    input  logic [ADDR_W-NB-1:0]   wr_addr_i,
    input  logic [DATA_W-1:0]      wr_wdata_i,
    input  logic [DATA_W/8-1:0]    wr_wstrb_i,
    output logic                   wr_ready_o,
    output logic                   wbuf_empty_o,
    input  logic                   replace_valid_i,
    input  logic [ADDR_W-LW-1:0]   replace_addr_i,
    output logic                   replace_o,
    output logic                   read_valid_o,
    output logic [LB-1:0]          read_addr_o,
    output logic [DATA_W-1:0]      read_rdata_o,
    output logic                   err_o,
    iob_cache_back_end_axi_wbuf_if.master axi
);
    localparam int PW = $clog2(WBUF_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_HOLD, R_ADDR, R_DATA} r_state_t;

    w_state_t r_wst, w_wst_nxt;
    r_state_t r_rst, w_rst_nxt;
    logic [ADDR_W-NB-1:0] r_addr_mem [WBUF_DEPTH];
    logic [DATA_W-1:0]    r_data_mem [WBUF_DEPTH];
    logic [DATA_W/8-1:0]  r_strb_mem [WBUF_DEPTH];
    logic [PW:0]          r_wptr, r_rptr, r_snap, w_count;
    logic [ADDR_W-LW-1:0] r_line;
    logic [LB-1:0]        r_beat;
    logic [WBUF_DEPTH-1:0] w_match;
    logic                 r_err, w_full, w_empty, w_push, w_pop, w_hit;

    // Occupancy never exceeds WBUF_DEPTH, so its top bit alone flags full.
    assign w_count      = r_wptr - r_rptr;
    assign w_empty      = w_count == '0;
    assign w_full       = w_count[PW];
    assign w_push       = wr_valid_i & ~w_full;
    assign w_pop        = (r_wst == W_RESP) & axi.axi_bvalid_i;
    assign wr_ready_o   = ~w_full;
    assign wbuf_empty_o = w_empty;
    assign replace_o    = r_rst != R_IDLE;
    assign read_addr_o  = r_beat;
    assign read_rdata_o = axi.axi_rdata_i;
    assign err_o        = r_err;

    assign axi.axi_awid_o    = AXI_ID;
    assign axi.axi_arid_o    = AXI_ID;
    assign axi.axi_awsize_o  = 3'(NB);
    assign axi.axi_arsize_o  = 3'(NB);
    assign axi.axi_awburst_o = 2'b01;
    assign axi.axi_arburst_o = 2'b01;
    assign axi.axi_awcache_o = CACHE_MODE;
    assign axi.axi_arcache_o = CACHE_MODE;

    for (genvar i = 0; i < WBUF_DEPTH; i++) begin : g_match
        logic [PW-1:0] w_off;
        assign w_off      = PW'(i) - r_rptr[PW-1:0];
        assign w_match[i] = ({1'b0, w_off} < w_count) && (r_addr_mem[i][ADDR_W-NB-1:LB] == replace_addr_i);
    end
    assign w_hit = |w_match;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_addr_mem[r_wptr[PW-1:0]] <= wr_addr_i;
            r_data_mem[r_wptr[PW-1:0]] <= wr_wdata_i;
            r_strb_mem[r_wptr[PW-1:0]] <= wr_wstrb_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wst  <= W_IDLE;
            r_rst  <= R_IDLE;
            r_wptr <= '0;
            r_rptr <= '0;
            r_snap <= '0;
            r_line <= '0;
            r_beat <= '0;
            r_err  <= 1'b0;
        end else begin
            r_wst <= w_wst_nxt;
            r_rst <= w_rst_nxt;
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            if (r_rst == R_IDLE && replace_valid_i) begin
                r_line <= replace_addr_i;
                r_snap <= r_wptr;
            end
            if (read_valid_o) r_beat <= axi.axi_rlast_i ? '0 : r_beat + 1'b1;
            if ((w_pop && axi.axi_bresp_i != 2'b00) || (read_valid_o && axi.axi_rresp_i != 2'b00)) r_err <= 1'b1;
        end
    end

    always_comb begin
        w_wst_nxt         = r_wst;
        axi.axi_awvalid_o = r_wst == W_ADDR;
        axi.axi_wvalid_o  = r_wst == W_DATA;
        axi.axi_wlast_o   = r_wst == W_DATA;
        axi.axi_bready_o  = r_wst == W_RESP;
        axi.axi_awaddr_o  = {r_addr_mem[r_rptr[PW-1:0]], {NB{1'b0}}};
        axi.axi_awlen_o   = '0;
        axi.axi_wdata_o   = r_data_mem[r_rptr[PW-1:0]];
        axi.axi_wstrb_o   = r_strb_mem[r_rptr[PW-1:0]];
        unique case (r_wst)
            W_IDLE:  w_wst_nxt = w_empty ? W_IDLE : W_ADDR;
            W_ADDR:  w_wst_nxt = axi.axi_awready_i ? W_DATA : W_ADDR;
            W_DATA:  w_wst_nxt = axi.axi_wready_i ? W_RESP : W_DATA;
            default: w_wst_nxt = axi.axi_bvalid_i ? W_IDLE : W_RESP;
        endcase
    end

    // The snapshot marks the youngest write the refill must wait for; later pushes are ignored.
    always_comb begin
        w_rst_nxt         = r_rst;
        axi.axi_arvalid_o = r_rst == R_ADDR;
        axi.axi_rready_o  = r_rst == R_DATA;
        axi.axi_araddr_o  = {r_line, {LW{1'b0}}};
        axi.axi_arlen_o   = AXI_LEN_W'(LINE_BEATS - 1);
        read_valid_o      = (r_rst == R_DATA) & axi.axi_rvalid_i;
        unique case (r_rst)
            R_IDLE:  w_rst_nxt = replace_valid_i ? (w_hit ? R_HOLD : R_ADDR) : R_IDLE;
            R_HOLD:  w_rst_nxt = (r_rptr == r_snap) ? R_ADDR : R_HOLD;
            R_ADDR:  w_rst_nxt = axi.axi_arready_i ? R_DATA : R_ADDR;
            default: w_rst_nxt = (axi.axi_rvalid_i && axi.axi_rlast_i) ? R_IDLE : R_DATA;
        endcase
    end
endmodule

// File: tb/tb_iob_cache_back_end_axi_wbuf.sv
// tb_iob_cache_back_end_axi_wbuf: directed checks of the write buffer, refill path, hazard stall,
// error flag and asynchronous reset of iob_cache_back_end_axi_wbuf at default parameters.
module tb_iob_cache_back_end_axi_wbuf;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic [29:0] wr_addr = '0;
    logic [31:0] wr_wdata = '0;
    logic [3:0]  wr_wstrb = '0;
    logic        wr_ready, wbuf_empty;
    logic        replace_valid = 1'b0;
    logic [27:0] replace_addr = '0;
    logic        replace, read_valid, err;
    logic [1:0]  read_addr;
    logic [31:0] read_rdata;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    iob_cache_back_end_axi_wbuf_if axi ();

    iob_cache_back_end_axi_wbuf dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_wdata_i(wr_wdata), .wr_wstrb_i(wr_wstrb),
        .wr_ready_o(wr_ready), .wbuf_empty_o(wbuf_empty),
        .replace_valid_i(replace_valid), .replace_addr_i(replace_addr), .replace_o(replace),
        .read_valid_o(read_valid), .read_addr_o(read_addr), .read_rdata_o(read_rdata),
        .err_o(err), .axi(axi)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [29:0] a, input logic [31:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_wdata = d;
        wr_wstrb = 4'hF;
        #1 chk("push_ready", wr_ready, 1);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_bready();
        for (int c = 0; c < 20 && !axi.axi_bready_o; c++) tick();
        chk("bready_reached", axi.axi_bready_o, 1);
    endtask

    task automatic refill_burst(input logic [31:0] line, input logic [31:0] base, input int bad);
        for (int c = 0; c < 20 && !axi.axi_arvalid_o; c++) tick();
        chk("arvalid", axi.axi_arvalid_o, 1);
        chk("araddr", axi.axi_araddr_o, line);
        chk("arlen", axi.axi_arlen_o, 3);
        axi.axi_arready_i = 1'b1;
        tick();
        axi.axi_arready_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            axi.axi_rvalid_i = 1'b1;
            axi.axi_rdata_i  = base + b;
            axi.axi_rlast_i  = (b == 3);
            axi.axi_rresp_i  = (b == bad) ? 2'b11 : 2'b00;
            #1;
            chk("rready", axi.axi_rready_o, 1);
            chk("read_valid", read_valid, 1);
            chk("read_addr", read_addr, b);
            chk("read_rdata", read_rdata, base + b);
            tick();
        end
        axi.axi_rvalid_i = 1'b0;
        axi.axi_rlast_i  = 1'b0;
        axi.axi_rresp_i  = 2'b00;
        #1;
        chk("replace_done", replace, 0);
        chk("read_idle", read_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n, nw, nb;
        axi.axi_awready_i = 1'b0;
        axi.axi_arready_i = 1'b0;
        axi.axi_wready_i  = 1'b0;
        axi.axi_bvalid_i  = 1'b0;
        axi.axi_bresp_i   = 2'b00;
        axi.axi_rvalid_i  = 1'b0;
        axi.axi_rlast_i   = 1'b0;
        axi.axi_rresp_i   = 2'b00;
        axi.axi_rdata_i   = '0;
        #12;
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_wbuf_empty", wbuf_empty, 1);
        chk("rst_replace", replace, 0);
        chk("rst_err", err, 0);
        chk("rst_awvalid", axi.axi_awvalid_o, 0);
        chk("rst_arvalid", axi.axi_arvalid_o, 0);
        chk("rst_rready", axi.axi_rready_o, 0);
        chk("tie_ids", {axi.axi_awid_o, axi.axi_arid_o}, 0);
        chk("tie_size", {axi.axi_awsize_o, axi.axi_arsize_o}, 6'o22);
        chk("tie_burst", {axi.axi_awburst_o, axi.axi_arburst_o}, 4'b0101);
        chk("tie_cache", {axi.axi_awcache_o, axi.axi_arcache_o}, 8'h33);
        rst_n = 1'b1;
        tick();

        // Fill the buffer while AW is stalled: the fifth push must be refused.
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 30'(32'h40 + i);
            wr_wdata = 32'hD0 + i;
            wr_wstrb = 4'hF;
            #1 chk("fill_ready", wr_ready, (i < 4));
            tick();
        end
        wr_valid = 1'b0;
        #1;
        chk("full_ready", wr_ready, 0);
        chk("aw_held", axi.axi_awvalid_o, 1);
        chk("aw_head", axi.axi_awaddr_o, 32'h100);
        chk("full_not_empty", wbuf_empty, 0);
        axi.axi_awready_i = 1'b1;
        axi.axi_wready_i  = 1'b1;
        axi.axi_bvalid_i  = 1'b1;
        n = 0; nw = 0; nb = 0;
        for (int c = 0; c < 40 && nb < 4; c++) begin
            if (axi.axi_awvalid_o) begin
                chk("aw_addr", axi.axi_awaddr_o, 32'h100 + 4 * n);
                chk("aw_len", axi.axi_awlen_o, 0);
                n++;
            end
            if (axi.axi_wvalid_o) begin
                chk("w_data", axi.axi_wdata_o, 32'hD0 + nw);
                chk("w_strb_last", {axi.axi_wstrb_o, axi.axi_wlast_o}, 5'h1F);
                nw++;
            end
            if (axi.axi_bready_o) nb++;
            tick();
        end
        axi.axi_bvalid_i = 1'b0;
        chk("aw_count", n, 4);
        chk("b_count", nb, 4);
        chk("drained_empty", wbuf_empty, 1);
        chk("drained_ready", wr_ready, 1);

        // Refill with an empty buffer issues AR on the next cycle.
        replace_valid = 1'b1;
        replace_addr  = 28'h200;
        #1 chk("req_idle", replace, 0);
        tick();
        replace_valid = 1'b0;
        #1;
        chk("replace_busy", replace, 1);
        chk("ar_next", axi.axi_arvalid_o, 1);
        refill_burst(32'h2000, 32'hA0, -1);

        // Same-line write pending its B response stalls the refill.
        push(30'h802, 32'h11);
        wait_bready();
        replace_valid = 1'b1;
        replace_addr  = 28'h200;
        tick();
        replace_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("hold_ar", axi.axi_arvalid_o, 0);
            chk("hold_busy", replace, 1);
            tick();
        end
        axi.axi_bvalid_i = 1'b1;
        tick();
        axi.axi_bvalid_i = 1'b0;
        chk("hold_popped", wbuf_empty, 1);
        refill_burst(32'h2000, 32'hB0, -1);

        // A write to another line does not stall the refill.
        push(30'hC00, 32'h22);
        wait_bready();
        replace_valid = 1'b1;
        replace_addr  = 28'h200;
        tick();
        replace_valid = 1'b0;
        #1 chk("nostall_ar", axi.axi_arvalid_o, 1);
        refill_burst(32'h2000, 32'hC0, -1);
        axi.axi_bvalid_i = 1'b1;
        tick();
        axi.axi_bvalid_i = 1'b0;
        chk("nostall_empty", wbuf_empty, 1);

        // Error responses set a sticky flag; transactions still complete.
        push(30'h100, 32'h33);
        wait_bready();
        axi.axi_bvalid_i = 1'b1;
        axi.axi_bresp_i  = 2'b10;
        #1 chk("err_before", err, 0);
        tick();
        axi.axi_bvalid_i = 1'b0;
        axi.axi_bresp_i  = 2'b00;
        #1;
        chk("err_set", err, 1);
        chk("err_write_retired", wbuf_empty, 1);
        replace_valid = 1'b1;
        replace_addr  = 28'h300;
        tick();
        replace_valid = 1'b0;
        refill_burst(32'h3000, 32'hE0, 1);
        tick();
        tick();
        chk("err_sticky", err, 1);

        // Asynchronous reset mid-burst and with a write in W_RESP.
        push(30'h140, 32'h44);
        wait_bready();
        replace_valid = 1'b1;
        replace_addr  = 28'h400;
        tick();
        replace_valid = 1'b0;
        axi.axi_arready_i = 1'b1;
        tick();
        axi.axi_arready_i = 1'b0;
        for (int b = 0; b < 3; b++) begin
            axi.axi_rvalid_i = 1'b1;
            axi.axi_rdata_i  = 32'hF0 + b;
            if (b < 2) tick();
        end
        #1 chk("mid_beat", read_addr, 2);
        rst_n = 1'b0;
        #1;
        chk("arst_valids", {axi.axi_awvalid_o, axi.axi_wvalid_o, axi.axi_bready_o, axi.axi_arvalid_o, axi.axi_rready_o, read_valid}, 0);
        chk("arst_replace", replace, 0);
        chk("arst_wr_ready", wr_ready, 1);
        chk("arst_empty", wbuf_empty, 1);
        chk("arst_err", err, 0);
        tick();
        chk("arst_hold", {replace, read_valid, axi.axi_rready_o, axi.axi_bready_o}, 0);
        axi.axi_rvalid_i = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_idle", {replace, axi.axi_awvalid_o, axi.axi_arvalid_o, wbuf_empty}, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
